// File: rtl/reg_cmd_driver.sv
// Command-driven sequencer for an external N-bit function register: issues enable
// pulses, then samples the register value. `define REG_CMD_DRIVER_SHADOW_EN adds a shadow checker.
module reg_cmd_driver #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_data,
   input  logic [3:0]   cmd_count,
   output logic [1:0]   FunSel,
   output logic [N-1:0] data_in,
   output logic         enable,
   input  logic [N-1:0] data_out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_data
`ifdef REG_CMD_DRIVER_SHADOW_EN
   ,
   output logic         mismatch
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t     r_state;
   logic [3:0] r_left;
   logic       w_idle;

   assign w_idle    = (r_state == IDLE);
   // Gated by rst so no command can be seen as accepted during a reset cycle.
   assign cmd_ready = w_idle && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_left    <= '0;
         FunSel    <= '0;
         data_in   <= '0;
         enable    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_left <= cmd_count;
                  if (cmd_count != 4'd0) begin
                     FunSel  <= cmd_op;
                     data_in <= cmd_data;
                     enable  <= 1'b1;
                     r_state <= ISSUE;
                  end else begin
                     r_state <= SETTLE;
                  end
               end
            end
            ISSUE: begin
               // r_left counts down to 1 rather than 0, so a count of 15 never wraps.
               if (r_left == 4'd1) begin
                  enable  <= 1'b0;
                  r_state <= SETTLE;
               end else begin
                  r_left <= r_left - 4'd1;
               end
            end
            SETTLE: begin
               rsp_data  <= data_out;
               rsp_valid <= 1'b1;
               r_state   <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef REG_CMD_DRIVER_SHADOW_EN
   logic [N-1:0] r_shadow;
   logic         r_shadow_known;

   function automatic logic [N-1:0] f_shadow_next(input logic [1:0]   op,
                                                  input logic [N-1:0] cur,
                                                  input logic [N-1:0] ld);
      logic [N-1:0] w_nxt;
      case (op)
         2'b00:   w_nxt = cur - N'(1);
         2'b01:   w_nxt = cur + N'(1);
         2'b10:   w_nxt = ld;
         default: w_nxt = '0;
      endcase
      return w_nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow       <= '0;
         r_shadow_known <= 1'b0;
         mismatch       <= 1'b0;
      end else begin
         if (enable) begin
            r_shadow <= f_shadow_next(FunSel, r_shadow, data_in);
            // Load and clear pin the register to a known value; inc/dec only track it.
            if (FunSel[1]) begin
               r_shadow_known <= 1'b1;
            end
         end
         if (r_state == SETTLE) begin
            mismatch <= r_shadow_known && (data_out != r_shadow);
         end else if (w_idle || (r_state == RESP && rsp_ready)) begin
            mismatch <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_cmd_driver.sv
// Scoreboard bench for reg_cmd_driver: directed commands against a simple function-register model.
module tb_reg_cmd_driver;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [N-1:0] cmd_data;
   logic [3:0]   cmd_count;
   logic [1:0]   FunSel;
   logic [N-1:0] data_in;
   logic         enable;
   logic [N-1:0] data_out;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_data;
`ifdef REG_CMD_DRIVER_SHADOW_EN
   logic         mismatch;
`endif

   int           total = 0;
   int           bad = 0;
   int           pulses = 0;
   logic [1:0]   exp_fs = 2'b00;
   logic [N-1:0] sb[$];
   logic [N-1:0] mon_exp;
   logic [N-1:0] reg_q = '0;

   always #5 clk = ~clk;

   reg_cmd_driver #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .FunSel    (FunSel),
      .data_in   (data_in),
      .enable    (enable),
      .data_out  (data_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
`ifdef REG_CMD_DRIVER_SHADOW_EN
      ,
      .mismatch  (mismatch)
`endif
   );

   // External function register driven by the DUT.
   assign data_out = reg_q;
   always @(posedge clk) begin
      if (enable) begin
         case (FunSel)
            2'b00:   reg_q <= reg_q - 4'd1;
            2'b01:   reg_q <= reg_q + 4'd1;
            2'b10:   reg_q <= data_in;
            default: reg_q <= '0;
         endcase
      end
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (enable) begin
         pulses++;
         check("funsel_pulse", {30'd0, FunSel}, {30'd0, exp_fs});
      end
   end

   // Scoreboard monitor: pops on every response handshake.
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
         end else begin
            mon_exp = sb.pop_front();
            check("rsp_data", {28'd0, rsp_data}, {28'd0, mon_exp});
`ifdef REG_CMD_DRIVER_SHADOW_EN
            check("mismatch", {31'd0, mismatch}, 32'd0);
`endif
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [N-1:0] data, input logic [3:0] cnt,
                       input logic [N-1:0] exp, input bit stall, input bit poke);
      int lat;
      sb.push_back(exp);
      exp_fs    = op;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
      cmd_valid = 1'b1;
      rsp_ready = !stall;
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pulses    = 0;
      if (poke) begin
         cmd_valid = 1'b1;
         cmd_op    = 2'b11;
         cmd_data  = '1;
         cmd_count = 4'd7;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!rsp_valid) check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      end while (!rsp_valid && lat < 40);
      cmd_valid = 1'b0;
      check("latency", lat, int'(cnt) + 2);
      check("pulses", pulses, int'(cnt));
      check("cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
      if (stall) begin
         repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", {28'd0, rsp_data}, {28'd0, exp});
            check("stall_ready", {31'd0, cmd_ready}, 32'd0);
         end
         @(posedge clk);
         #1;
         rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
      check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = '0;
      cmd_count = 4'd0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_enable", {31'd0, enable}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_funsel", {30'd0, FunSel}, 32'd0);
      check("rst_data_in", {28'd0, data_in}, 32'd0);
      check("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("release_ready", {31'd0, cmd_ready}, 32'd1);

      send(2'b10, 4'b0010, 4'd1,  4'b0010, 1'b0, 1'b0);  // load
      send(2'b01, 4'b0000, 4'd3,  4'b0101, 1'b0, 1'b0);  // +3
      send(2'b11, 4'b0000, 4'd1,  4'b0000, 1'b0, 1'b0);  // clear
      send(2'b00, 4'b0011, 4'd1,  4'b1111, 1'b0, 1'b0);  // 0-1 wraps
      send(2'b01, 4'b1010, 4'd0,  4'b1111, 1'b0, 1'b0);  // readback only
      check("hold_funsel", {30'd0, FunSel}, 32'd0);
      check("hold_data_in", {28'd0, data_in}, 32'd3);
      send(2'b01, 4'b0000, 4'd15, 4'b1110, 1'b0, 1'b0);  // 15+15 mod 16
      send(2'b10, 4'b1001, 4'd2,  4'b1001, 1'b1, 1'b0);  // stalled consumer
      send(2'b10, 4'b0110, 4'd2,  4'b0110, 1'b0, 1'b1);  // busy cmd_valid ignored

      // Reset during the first pulse of a 5-pulse increment.
      exp_fs    = 2'b01;
      cmd_op    = 2'b01;
      cmd_data  = '0;
      cmd_count = 4'd5;
      cmd_valid = 1'b1;
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pulses    = 0;
      rst       = 1'b1;
      @(negedge clk);
      check("midrst_enable", {31'd0, enable}, 32'd1);
      check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("postrst_enable", {31'd0, enable}, 32'd0);
      check("postrst_funsel", {30'd0, FunSel}, 32'd0);
      check("postrst_data_in", {28'd0, data_in}, 32'd0);
      check("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("postrst_rsp_data", {28'd0, rsp_data}, 32'd0);
      check("postrst_ready", {31'd0, cmd_ready}, 32'd1);
      check("postrst_pulses", pulses, 1);
      check("postrst_reg", {28'd0, reg_q}, 32'h7);
      repeat (4) begin
         @(negedge clk);
         check("quiet_enable", {31'd0, enable}, 32'd0);
         check("quiet_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      check("quiet_pulses", pulses, 1);

      send(2'b01, 4'b0000, 4'd0, 4'b0111, 1'b0, 1'b0);   // recovers after reset
      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_cmd_driver.md
REG_CMD_DRIVER -- requirements
Module: reg_cmd_driver

Interface
REQ-001 The block SHALL have parameter N, default 4, the width of the driven register.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1, a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1, a command is accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-006 The block SHALL have port cmd_op, input, 2, the register operation: 00 decrement, 01 increment, 10 load, 11 clear.
REQ-007 The block SHALL have port cmd_data, input, N, the load operand.
REQ-008 The block SHALL have port cmd_count, input, 4, the number of enable pulses to issue.
REQ-009 The block SHALL have port FunSel, output, 2, the register function select.
REQ-010 The block SHALL have port data_in, output, N, the register load data.
REQ-011 The block SHALL have port enable, output, 1, the register enable.
REQ-012 The block SHALL have port data_out, input, N, the register's current value.
REQ-013 The block SHALL have port rsp_valid, output, 1, a result is available.
REQ-014 The block SHALL have port rsp_ready, input, 1, the consumer accepts the result.
REQ-015 The block SHALL have port rsp_data, output, N, the sampled register value.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, SETTLE and RESP.
REQ-017 cmd_ready SHALL be high only in IDLE.
REQ-018 On acceptance, the block SHALL latch op, data and count. It SHALL go to ISSUE if count>0, else to SETTLE (readback only).
REQ-019 In ISSUE, enable SHALL be 1, FunSel SHALL equal the latched op and data_in SHALL equal the latched data, for exactly count consecutive cycles. The block SHALL then go to SETTLE.
REQ-020 Outside ISSUE, enable SHALL be 0, while FunSel and data_in hold their last values.
REQ-021 SETTLE SHALL last one cycle. At its end, rsp_data SHALL capture data_out and the FSM SHALL go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_data SHALL be stable. On rsp_ready, the FSM SHALL return to IDLE the next cycle.
REQ-023 Latency from command acceptance to rsp_valid SHALL be count+2 cycles.
REQ-024 rsp_ready asserted outside RESP SHALL be ignored.
REQ-025 cmd_valid asserted while busy SHALL NOT be accepted and SHALL NOT disturb the active command.
REQ-026 A count of 15 SHALL issue 15 pulses, with no counter overflow.

Reset
REQ-027 When rst is high at a clk edge, the block SHALL enter IDLE and clear state: FunSel=00, data_in=0, enable=0, rsp_valid=0, rsp_data=0.
REQ-028 rst asserted mid-ISSUE SHALL drop enable in the following cycle, with no further pulses and no response.
REQ-029 cmd_ready SHALL be 0 while rst is high and 1 in the first cycle after release.

Configuration
REQ-030 Macro REG_CMD_DRIVER_SHADOW_EN SHALL control the shadow checker.
- Defined: the block SHALL add output mismatch (1 bit) and keep an N-bit shadow plus a shadow_known flag, both cleared by rst.
- Shadow update: load and clear set shadow_known. Increment and decrement wrap modulo 2^N; all-ones+1 gives 0 and 0-1 gives all-ones.
- Each enable pulse SHALL update the shadow per op.
- At SETTLE, mismatch SHALL be set to shadow_known AND (data_out != shadow). It SHALL be held through RESP and cleared in IDLE.
- Undefined: there SHALL be no mismatch port and no shadow logic.

Verification
REQ-031 Scenario: load 0010, count 1 -> one enable pulse with FunSel=10; rsp_data=0010 exactly 3 cycles after acceptance.
REQ-032 Scenario: increment, count 3, from 0010 -> three consecutive enable cycles with FunSel=01; rsp_data=0101.
REQ-033 Scenario: clear then decrement, count 1 -> rsp_data=1111 (wrap); with SHADOW_EN, mismatch=0.
REQ-034 Scenario: count 0 -> enable never asserted; rsp_data equals current data_out; latency 2 cycles.
REQ-035 Scenario: rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable; cmd_ready low throughout.
REQ-036 Scenario: rst asserted in the second cycle of an increment with count 5 -> exactly 1 enable pulse issued; the next cycle is IDLE with all outputs at reset values.
